// File: rtl/mips_pkg.sv
// mips_pkg: shared MEM-stage types and constants.
//   DATA_W          - default data/address width
//   WORD_ALIGN_MASK - low address bits that must be zero for a word access
//   mem_state_t     - MEM stage FSM states
//   ctrl_mem_t      - the five EX/MEM control bits bundled together
package mips_pkg;

    localparam int         DATA_W          = 32;
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    typedef enum logic {IDLE, WAIT} mem_state_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic reg_write;
        logic mem_to_reg;
    } ctrl_mem_t;

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with load enable and async active-low clear.
//   clk, rst_n                      - clock, asynchronous active-low clear
//   load_i                          - capture the *_i fields; valid_o pulses the cycle after
//   alu_out_i, rdata_i, wreg_i,
//   reg_write_i, mem_to_reg_i       - fields to capture
//   valid_o and field outputs       - registered MEM/WB contents (fields hold when not loaded)
module mem_wb_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [REG_W-1:0]  wreg_i,
    input  logic              reg_write_i,
    input  logic              mem_to_reg_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] alu_out_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [REG_W-1:0]  wreg_o,
    output logic              reg_write_o,
    output logic              mem_to_reg_o
);

    logic              valid_q, reg_write_q, mem_to_reg_q;
    logic [DATA_W-1:0] alu_out_q, rdata_q;
    logic [REG_W-1:0]  wreg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            alu_out_q    <= '0;
            rdata_q      <= '0;
            wreg_q       <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q <= load_i;
            if (load_i) begin
                alu_out_q    <= alu_out_i;
                rdata_q      <= rdata_i;
                wreg_q       <= wreg_i;
                reg_write_q  <= reg_write_i;
                mem_to_reg_q <= mem_to_reg_i;
            end
        end
    end

    assign valid_o      = valid_q;
    assign alu_out_o    = alu_out_q;
    assign rdata_o      = rdata_q;
    assign wreg_o       = wreg_q;
    assign reg_write_o  = reg_write_q;
    assign mem_to_reg_o = mem_to_reg_q;

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage - data-memory req/ack access, branch resolution, MEM/WB output.
//   clk, reset (async active-low)
//   ex_*        - EX/MEM register contents; ex_ready stalls upstream while an access is outstanding
//   dmem_*      - data-memory request (held stable until ack) and response
//   pc_src/pc_target - taken-branch pulse and target
//   wb_*        - MEM/WB register contents; misalign_err pulses for a dropped misaligned op
module mem_access_stage #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_wreg,
    input  logic [DATA_W-1:0] ex_branch_target,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_branch,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    output logic              ex_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_target,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_alu_out,
    output logic [DATA_W-1:0] wb_rdata,
    output logic [REG_W-1:0]  wb_wreg,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic              misalign_err
);

    import mips_pkg::*;

    mem_state_t        state_q;
    logic              dmem_req_q, dmem_we_q, pc_src_q, misalign_q;
    logic              reg_write_q, mem_to_reg_q;
    logic [DATA_W-1:0] dmem_addr_q, dmem_wdata_q, pc_target_q;
    logic [REG_W-1:0]  wreg_q;

    ctrl_mem_t         ctrl;
    logic              accept, is_mem, misaligned, start_access, take_branch, ack_done;
    logic              wb_load, wb_reg_write_d, wb_mem_to_reg_d;
    logic [DATA_W-1:0] wb_alu_out_d, wb_rdata_d;
    logic [REG_W-1:0]  wb_wreg_d;

    assign ctrl = '{mem_read: ex_mem_read, mem_write: ex_mem_write, branch: ex_branch,
                    reg_write: ex_reg_write, mem_to_reg: ex_mem_to_reg};

    // The latched access (dmem_addr_q doubles as the latched ALU result) feeds WB on ack;
    // otherwise WB takes the EX/MEM contents directly.
    always_comb begin
        accept          = ex_valid && state_q == IDLE;
        is_mem          = ctrl.mem_read || ctrl.mem_write;
        misaligned      = (ex_alu_out[1:0] & WORD_ALIGN_MASK) != 2'b00;
        start_access    = accept && is_mem && !misaligned;
        take_branch     = accept && ctrl.branch && ex_zero;
        ack_done        = state_q == WAIT && dmem_ack;
        wb_load         = ack_done || (accept && !start_access);
        wb_alu_out_d    = ack_done ? dmem_addr_q : ex_alu_out;
        wb_rdata_d      = (ack_done && !dmem_we_q) ? dmem_rdata : '0;
        wb_wreg_d       = ack_done ? wreg_q : ex_wreg;
        wb_reg_write_d  = ack_done ? reg_write_q : ctrl.reg_write && !is_mem;
        wb_mem_to_reg_d = ack_done ? mem_to_reg_q : ctrl.mem_to_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            wreg_q       <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            pc_src_q     <= 1'b0;
            pc_target_q  <= '0;
            misalign_q   <= 1'b0;
        end else begin
            pc_src_q   <= take_branch;
            misalign_q <= accept && is_mem && misaligned;
            if (take_branch) pc_target_q <= ex_branch_target;
            if (start_access) begin
                state_q      <= WAIT;
                dmem_req_q   <= 1'b1;
                dmem_we_q    <= ctrl.mem_write;
                dmem_addr_q  <= ex_alu_out;
                dmem_wdata_q <= ex_store_data;
                wreg_q       <= ex_wreg;
                reg_write_q  <= ctrl.reg_write;
                mem_to_reg_q <= ctrl.mem_to_reg;
            end else if (ack_done) begin
                state_q    <= IDLE;
                dmem_req_q <= 1'b0;
            end
        end
    end

    mem_wb_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_mem_wb_reg (
        .clk          (clk),
        .rst_n        (reset),
        .load_i       (wb_load),
        .alu_out_i    (wb_alu_out_d),
        .rdata_i      (wb_rdata_d),
        .wreg_i       (wb_wreg_d),
        .reg_write_i  (wb_reg_write_d),
        .mem_to_reg_i (wb_mem_to_reg_d),
        .valid_o      (wb_valid),
        .alu_out_o    (wb_alu_out),
        .rdata_o      (wb_rdata),
        .wreg_o       (wb_wreg),
        .reg_write_o  (wb_reg_write),
        .mem_to_reg_o (wb_mem_to_reg)
    );

    assign ex_ready     = state_q == IDLE;
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign pc_src       = pc_src_q;
    assign pc_target    = pc_target_q;
    assign misalign_err = misalign_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the segmented processor: consumes the contents of the EX/MEM pipeline register and performs data-memory loads and stores over a req/ack handshake. It resolves branches from the registered zero flag and branch target, and produces the MEM/WB register contents. While a memory access is outstanding, it deasserts `ex_ready` to stall the upstream pipeline.

## Interface

Parameters:
- `DATA_W`, 32, data and address width
- `REG_W`, 5, destination register index width

Ports:
- `clk`  in  1  — system clock; all state updates on rising edge
- `reset`  in  1  — asynchronous, active-low reset
- `ex_valid`  in  1  — EX/MEM register holds a valid instruction
- `ex_alu_out`  in  DATA_W  — ALU result / memory byte address
- `ex_zero`  in  1  — registered ALU zero flag
- `ex_store_data`  in  DATA_W  — second-operand data for stores
- `ex_wreg`  in  REG_W  — destination register index
- `ex_branch_target`  in  DATA_W  — computed branch target
- `ex_mem_read`, `ex_mem_write`, `ex_branch`, `ex_reg_write`, `ex_mem_to_reg`  in  1 each  — control bits
- `ex_ready`  out  1  — stage accepts EX/MEM contents this cycle
- `dmem_req`  out  1  — data-memory request
- `dmem_we`  out  1  — 1 = write, 0 = read
- `dmem_addr`  out  DATA_W  — word-aligned address
- `dmem_wdata`  out  DATA_W  — store data
- `dmem_ack`  in  1  — memory completes the request
- `dmem_rdata`  in  DATA_W  — load data, valid with `dmem_ack`
- `pc_src`  out  1  — one-cycle pulse: take branch
- `pc_target`  out  DATA_W  — branch target, valid with `pc_src`
- `wb_valid`  out  1  — MEM/WB register valid, one-cycle pulse per instruction
- `wb_alu_out`, `wb_rdata`  out  DATA_W  — ALU result, load data
- `wb_wreg`  out  REG_W; `wb_reg_write`, `wb_mem_to_reg`  out  1  — forwarded destination and control
- `misalign_err`  out  1  — one-cycle pulse: misaligned memory op dropped

## Operation

- States: `IDLE`, `WAIT`. `ex_ready = (state == IDLE)`.
- Acceptance occurs when `ex_valid && ex_ready`.
- Non-memory op accepted in `IDLE`:
  - Next edge: `wb_valid=1`, with `wb_alu_out`, `wb_wreg`, `wb_reg_write`, `wb_mem_to_reg` copied and `wb_rdata=0`.
  - State stays `IDLE`.
- Memory op (`ex_mem_read | ex_mem_write`) with `ex_alu_out[1:0]==0`:
  - Latch all inputs.
  - Next edge: `dmem_req=1`, `dmem_we=ex_mem_write`, `dmem_addr=ex_alu_out`, `dmem_wdata=ex_store_data`; state goes to `WAIT`.
  - If both read and write are set, write wins.
- In `WAIT`:
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` are held stable until `dmem_ack` is sampled high.
  - On that edge: `dmem_req=0`, state goes to `IDLE`, `wb_valid=1`.
  - `wb_rdata = dmem_rdata` for reads, 0 for writes.
  - Remaining `wb_*` fields come from the latch.
- Misaligned memory op:
  - No request is issued.
  - Next edge: `misalign_err=1` and `wb_valid=1`, with `wb_reg_write` forced 0.
  - State stays `IDLE`.
- Branch resolution:
  - Condition: acceptance with `ex_branch && ex_zero`.
  - Next edge: `pc_src=1` and `pc_target=ex_branch_target`, for one cycle.
  - `pc_target` holds its last value otherwise.
- `dmem_ack` outside `WAIT` is ignored.
- `ex_valid=0` in `IDLE` produces no pulses.

## Timing

- Reset (`reset=0`, asynchronous):
  - State goes to `IDLE`.
  - All outputs become 0, including `dmem_req` immediately.
  - `ex_ready` becomes 1.
  - Any outstanding access is abandoned; an ack after reset release is ignored.
- Non-memory and misaligned ops: latency 1 cycle, throughput 1 per cycle.
- Memory op accepted at edge T:
  - `dmem_req` is high from T+1.
  - If ack is sampled at edge T+k (k≥1), `wb_valid` is high in cycle T+k to T+k+1, and `ex_ready` returns to 1 in the same cycle.
  - A new instruction can be accepted at edge T+k+1.
- `wb_valid`, `pc_src`, `misalign_err` are single-cycle pulses registered from the same acceptance edge.

## Structure

- Shared package `mips_pkg`:
  - State enum `mem_state_t {IDLE, WAIT}`
  - Constants `WORD_ALIGN_MASK = 2'b11` and `DATA_W`
  - Typedef `ctrl_mem_t` bundling the five control bits
- One sub-module, `mem_wb_reg`: the MEM/WB output register with load enable and async active-low clear. The FSM and dmem handshake stay in `mem_access_stage`.

## Test plan

- ALU op `ex_alu_out=0x0000_0010`, `ex_wreg=5`, `reg_write=1` → next cycle `wb_valid=1`, `wb_alu_out=0x10`, `wb_wreg=5`, `wb_rdata=0`, `ex_ready` stays 1.
- Load at `0x0000_0100`, ack after 3 req cycles with `rdata=0xDEAD_BEEF`:
  - `dmem_req` is high for exactly 3 cycles, with addr stable and `we=0`.
  - `ex_ready=0` for 3 cycles.
  - Then `wb_rdata=0xDEAD_BEEF`, `wb_mem_to_reg=1`.
- Store `0x1234_5678` to `0x0000_0200`, ack at first req cycle → `dmem_we=1`, `dmem_wdata=0x1234_5678`, `wb_valid` 1 cycle later, `wb_rdata=0`.
- Branch with `zero=1`, target `0x0000_0040` → `pc_src` pulse 1 cycle with `pc_target=0x40`; with `zero=0` → no pulse.
- Load at `0x0000_0102` → `misalign_err` pulse, no `dmem_req`, `wb_valid=1` with `wb_reg_write=0`.
- Reset asserted mid-`WAIT` → `dmem_req` drops without waiting for a clock edge; a later `dmem_ack=1` produces no `wb_valid`, and `ex_ready=1`.
